// File: rtl/seq_tx_fmt_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seq_tx_fmt_pkg
//  Purpose : Shared definitions for the sequencer result formatter: default
//            datapath widths, ASCII constants, FSM state encoding and a
//            helper that computes the number of hex digits for a word width.
//  Rev     : 1.0  initial release
// ============================================================================
package seq_tx_fmt_pkg;

    // Defaults for the sequencer datapath and register-number widths.
    localparam int SEQ_DP_WIDTH = 8;
    localparam int SEQ_RN_WIDTH = 2;

    // ASCII characters used to build a line.
    localparam logic [7:0] c_asc_r     = 8'h52;  // 'R'
    localparam logic [7:0] c_asc_colon = 8'h3A;  // ':'
    localparam logic [7:0] c_asc_cr    = 8'h0D;
    localparam logic [7:0] c_asc_lf    = 8'h0A;
    localparam logic [7:0] c_asc_0     = 8'h30;  // '0'
    localparam logic [7:0] c_asc_a     = 8'h41;  // 'A'

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_WAIT = 2'd3
    } fmt_state_t;

    // Hex digits needed to print a word of the given width (rounded up).
    function automatic int nib_count(input int width);
        return (width + 3) / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx_fmt_hex_ascii.sv
`default_nettype none
// ============================================================================
//  Module  : seq_hex_ascii
//  Purpose : Combinational conversion of a 4-bit nibble to its uppercase
//            ASCII hex character ('0'..'9', 'A'..'F').
//  Ports   : i_nib  [3:0]  nibble in
//            o_asc  [7:0]  ASCII character out
//  Rev     : 1.0  initial release
// ============================================================================
module seq_hex_ascii
    import seq_tx_fmt_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_asc
);

    always_comb begin
        if (i_nib < 4'd10) begin
            o_asc = c_asc_0 + {4'h0, i_nib};
        end else begin
            o_asc = c_asc_a + {4'h0, i_nib} - 8'd10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_tx_fmt.sv
`default_nettype none
// ============================================================================
//  Module  : seq_tx_fmt
//  Purpose : Formats each sequencer result word as an ASCII line
//            "R<reg>:<hex data>\r\n" and streams it byte by byte into the
//            UART byte transmitter.
//  Ports   : clk          system clock
//            rst          synchronous active-high reset
//            i_tx_data    result word (DP_WIDTH)
//            i_reg_num    register number (RN_WIDTH, <= 4)
//            i_tx_stb     1-cycle strobe qualifying i_tx_data/i_reg_num
//            i_uart_busy  byte transmitter busy
//            o_busy       line in progress; new strobes are dropped
//            o_byte       ASCII byte (held between strobes)
//            o_byte_stb   1-cycle strobe qualifying o_byte
//            o_drop_cnt   saturating count of dropped strobes
//  Config  : SEQ_TX_FMT_DROP_CNT_EN  enables the drop counter; when not
//            defined o_drop_cnt is tied to zero.
//  Rev     : 1.0  initial release
// ============================================================================
module seq_tx_fmt
    import seq_tx_fmt_pkg::*;
#(
    parameter int DP_WIDTH = SEQ_DP_WIDTH,
    parameter int RN_WIDTH = SEQ_RN_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DP_WIDTH-1:0] i_tx_data,
    input  logic [RN_WIDTH-1:0] i_reg_num,
    input  logic                i_tx_stb,
    input  logic                i_uart_busy,
    output logic                o_busy,
    output logic [7:0]          o_byte,
    output logic                o_byte_stb,
    output logic [7:0]          o_drop_cnt
);

    localparam int NIB   = nib_count(DP_WIDTH);
    localparam int LAST  = NIB + 4;
    localparam int IDX_W = $clog2(LAST + 1);

    // Byte positions within a line.
    localparam logic [IDX_W-1:0] c_idx_r     = IDX_W'(0);
    localparam logic [IDX_W-1:0] c_idx_reg   = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_idx_colon = IDX_W'(2);
    localparam logic [IDX_W-1:0] c_idx_cr    = IDX_W'(NIB + 3);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(LAST);

    fmt_state_t            r_state;
    fmt_state_t            w_state_nxt;
    logic [DP_WIDTH-1:0]   r_data;
    logic [RN_WIDTH-1:0]   r_reg;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_busy;
    logic [7:0]            r_byte;

    logic                  w_byte_stb;
    logic                  w_stb_out;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_last;
    logic [NIB*4-1:0]      w_data_pad;
    logic [3:0]            w_data_nib;
    logic [3:0]            w_reg_nib;
    logic [7:0]            w_data_asc;
    logic [7:0]            w_reg_asc;
    logic [7:0]            w_char;

    assign w_last   = (r_idx == c_idx_last);
    assign w_accept = (r_state == ST_IDLE) && i_tx_stb;

    // ------------------------------------------------------------------------
    // FSM: next state and byte strobe
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_byte_stb  = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_tx_stb) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!i_uart_busy) begin
                    w_byte_stb  = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            // One dead cycle so the UART has time to raise its busy flag.
            ST_GAP: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_uart_busy) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = ST_SEND;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A reset cycle must never emit a byte, even if the FSM sits in SEND.
    assign w_stb_out = w_byte_stb && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
            r_reg   <= '0;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_data <= i_tx_data;
                r_reg  <= i_reg_num;
                r_idx  <= '0;
            end else if (w_advance) begin
                r_idx  <= r_idx + IDX_W'(1);
            end
            if (w_stb_out) begin
                r_byte <= w_char;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Character selection
    // ------------------------------------------------------------------------
    always_comb begin
        // Zero-pad the word up to a whole number of nibbles.
        w_data_pad                = '0;
        w_data_pad[DP_WIDTH-1:0]  = r_data;
        w_reg_nib                 = '0;
        w_reg_nib[RN_WIDTH-1:0]   = r_reg;
        // Index 3 prints the most significant nibble.
        w_data_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (r_idx == IDX_W'(3 + k)) begin
                w_data_nib = w_data_pad[(NIB-1-k)*4 +: 4];
            end
        end
    end

    seq_hex_ascii u_hex_reg (
        .i_nib (w_reg_nib),
        .o_asc (w_reg_asc)
    );

    seq_hex_ascii u_hex_data (
        .i_nib (w_data_nib),
        .o_asc (w_data_asc)
    );

    always_comb begin
        if (r_idx == c_idx_r) begin
            w_char = c_asc_r;
        end else if (r_idx == c_idx_reg) begin
            w_char = w_reg_asc;
        end else if (r_idx == c_idx_colon) begin
            w_char = c_asc_colon;
        end else if (r_idx == c_idx_cr) begin
            w_char = c_asc_cr;
        end else if (r_idx == c_idx_last) begin
            w_char = c_asc_lf;
        end else begin
            w_char = w_data_asc;
        end
    end

    // The live character is presented in the strobe cycle; afterwards the
    // registered copy holds it.
    assign o_byte     = w_stb_out ? w_char : r_byte;
    assign o_byte_stb = w_stb_out;
    assign o_busy     = r_busy;

    // ------------------------------------------------------------------------
    // Optional dropped-strobe counter
    // ------------------------------------------------------------------------
`ifdef SEQ_TX_FMT_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic       w_drop;

    // o_busy covers the return-to-IDLE cycle, so strobes there are dropped too.
    assign w_drop = i_tx_stb && r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    assign o_drop_cnt = 8'h00;
`endif

endmodule
`default_nettype wire
